// File: rtl/bsg_axil_irq_collector.sv
// bsg_axil_irq_collector: AXI-Lite doorbell collector with pending/enable registers
// and a registered level interrupt; one outstanding transaction at a time.
module bsg_axil_irq_collector #(
    parameter int          axil_data_width_p = 32,
    parameter int          axil_addr_width_p = 32,
    parameter int          irq_sources_p     = 2,
    parameter logic [31:0] base_addr_p       = 32'h00000000
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [axil_addr_width_p-1:0] s_axil_awaddr_i,
    input  logic [2:0]                   s_axil_awprot_i,
    input  logic                         s_axil_awvalid_i,
    output logic                         s_axil_awready_o,
    input  logic [axil_data_width_p-1:0] s_axil_wdata_i,
    input  logic [3:0]                   s_axil_wstrb_i,
    input  logic                         s_axil_wvalid_i,
    output logic                         s_axil_wready_o,
    output logic [1:0]                   s_axil_bresp_o,
    output logic                         s_axil_bvalid_o,
    input  logic                         s_axil_bready_i,
    input  logic [axil_addr_width_p-1:0] s_axil_araddr_i,
    input  logic [2:0]                   s_axil_arprot_i,
    input  logic                         s_axil_arvalid_i,
    output logic                         s_axil_arready_o,
    output logic [axil_data_width_p-1:0] s_axil_rdata_o,
    output logic [1:0]                   s_axil_rresp_o,
    output logic                         s_axil_rvalid_o,
    input  logic                         s_axil_rready_i,
    output logic [irq_sources_p-1:0]     pending_o,
    output logic                         irq_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRESP = 2'd1;
    localparam logic [1:0] RRESP = 2'd2;
    localparam logic [axil_addr_width_p-1:0] base_lp     = axil_addr_width_p'(base_addr_p);
    localparam logic [axil_addr_width_p-1:0] db_end_lp   = axil_addr_width_p'(4 * irq_sources_p);
    localparam logic [axil_addr_width_p-1:0] pend_off_lp = axil_addr_width_p'(32'h40);
    localparam logic [axil_addr_width_p-1:0] en_off_lp   = axil_addr_width_p'(32'h44);
    localparam logic [axil_addr_width_p-1:0] stat_off_lp = axil_addr_width_p'(32'h48);

    logic [1:0]                   state_q, state_d;
    logic [irq_sources_p-1:0]     pending_q, pending_d, enable_q, enable_d, db_mask;
    logic                         irq_q;
    logic [1:0]                   bresp_q, bresp_d, rresp_q, rresp_d;
    logic [axil_data_width_p-1:0] rdata_q, rdata_d, rd_word;
    logic [axil_addr_width_p-1:0] woff, roff;
    logic [15:0]                  pend16;
    logic                         wr_acc, rd_acc, w_mapped, r_mapped;
    logic                         unused_w;

    // Anything below the base wraps to a huge offset and lands in the unmapped range.
    function automatic logic mapped(input logic [axil_addr_width_p-1:0] off);
        return off[1:0] == 2'b00 &&
               (off < db_end_lp || off == pend_off_lp || off == en_off_lp || off == stat_off_lp);
    endfunction

    assign woff     = s_axil_awaddr_i - base_lp;
    assign roff     = s_axil_araddr_i - base_lp;
    assign w_mapped = mapped(woff);
    assign r_mapped = mapped(roff);
    assign wr_acc   = state_q == IDLE && s_axil_awvalid_i && s_axil_wvalid_i;
    assign rd_acc   = state_q == IDLE && s_axil_arvalid_i && !(s_axil_awvalid_i && s_axil_wvalid_i);
    assign db_mask  = irq_sources_p'(1) << woff[5:2];
    assign pend16   = 16'(pending_q);
    assign rd_word  = roff < db_end_lp    ? axil_data_width_p'(pend16[roff[5:2]])
                    : roff == pend_off_lp ? axil_data_width_p'(pending_q)
                    : roff == en_off_lp   ? axil_data_width_p'(enable_q)
                    :                       axil_data_width_p'(pending_q & enable_q);
    assign unused_w = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_wstrb_i,
                        s_axil_wdata_i[axil_data_width_p-1:irq_sources_p]};

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        enable_d  = enable_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (wr_acc) begin
            state_d = WRESP;
            bresp_d = w_mapped ? 2'b00 : 2'b10;
            if (w_mapped && woff < db_end_lp) pending_d = pending_q | db_mask;
            if (woff == pend_off_lp) pending_d = pending_q & ~s_axil_wdata_i[irq_sources_p-1:0];
            if (woff == en_off_lp) enable_d = s_axil_wdata_i[irq_sources_p-1:0];
        end else if (rd_acc) begin
            state_d = RRESP;
            rresp_d = r_mapped ? 2'b00 : 2'b10;
            rdata_d = r_mapped ? rd_word : '0;
        end else if ((state_q == WRESP && s_axil_bready_i) || (state_q == RRESP && s_axil_rready_i)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            enable_q  <= '0;
            irq_q     <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            irq_q     <= |(pending_q & enable_q);
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Readies are combinational on the valids, so mask them while reset is held.
    assign s_axil_awready_o = wr_acc && !reset_i;
    assign s_axil_wready_o  = wr_acc && !reset_i;
    assign s_axil_arready_o = rd_acc && !reset_i;
    assign s_axil_bvalid_o  = state_q == WRESP;
    assign s_axil_rvalid_o  = state_q == RRESP;
    assign s_axil_bresp_o   = bresp_q;
    assign s_axil_rresp_o   = rresp_q;
    assign s_axil_rdata_o   = rdata_q;
    assign pending_o        = pending_q;
    assign irq_o            = irq_q;
endmodule

// File: tb/tb_bsg_axil_irq_collector.sv
// tb_bsg_axil_irq_collector: directed stimulus with a per-cycle model compare and literal spot checks.
module tb_bsg_axil_irq_collector;
    localparam int N = 2;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] s_axil_awaddr_i, s_axil_wdata_i, s_axil_araddr_i, s_axil_rdata_o;
    logic [2:0]  s_axil_awprot_i, s_axil_arprot_i;
    logic [3:0]  s_axil_wstrb_i;
    logic        s_axil_awvalid_i, s_axil_awready_o, s_axil_wvalid_i, s_axil_wready_o;
    logic [1:0]  s_axil_bresp_o, s_axil_rresp_o;
    logic        s_axil_bvalid_o, s_axil_bready_i, s_axil_arvalid_i, s_axil_arready_o;
    logic        s_axil_rvalid_o, s_axil_rready_i;
    logic [N-1:0] pending_o;
    logic        irq_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    bsg_axil_irq_collector #(
        .axil_data_width_p(32), .axil_addr_width_p(32), .irq_sources_p(N), .base_addr_p(BASE)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_axil_awaddr_i(s_axil_awaddr_i), .s_axil_awprot_i(s_axil_awprot_i),
        .s_axil_awvalid_i(s_axil_awvalid_i), .s_axil_awready_o(s_axil_awready_o),
        .s_axil_wdata_i(s_axil_wdata_i), .s_axil_wstrb_i(s_axil_wstrb_i),
        .s_axil_wvalid_i(s_axil_wvalid_i), .s_axil_wready_o(s_axil_wready_o),
        .s_axil_bresp_o(s_axil_bresp_o), .s_axil_bvalid_o(s_axil_bvalid_o),
        .s_axil_bready_i(s_axil_bready_i),
        .s_axil_araddr_i(s_axil_araddr_i), .s_axil_arprot_i(s_axil_arprot_i),
        .s_axil_arvalid_i(s_axil_arvalid_i), .s_axil_arready_o(s_axil_arready_o),
        .s_axil_rdata_o(s_axil_rdata_o), .s_axil_rresp_o(s_axil_rresp_o),
        .s_axil_rvalid_o(s_axil_rvalid_o), .s_axil_rready_i(s_axil_rready_i),
        .pending_o(pending_o), .irq_o(irq_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: register file as bit arrays, outstanding response as 0 none / 1 write / 2 read.
    bit          m_pend[N];
    bit          m_en[N];
    bit          m_irq;
    int          m_out;
    logic [1:0]  m_resp;
    logic [31:0] m_rdata;
    int          wc, rc;

    function automatic int classify(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off[1:0] != 2'b00 || off >= 32'h50) return -1;
        if (off < 32'h40) return (off / 4 < N) ? int'(off / 4) : -1;
        if (off == 32'h40) return 100;
        if (off == 32'h44) return 101;
        if (off == 32'h48) return 102;
        return -1;
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [31:0] en_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_en[i];
        return v;
    endfunction

    function automatic logic [31:0] read_val(input int c);
        if (c < 0) return 32'h0;
        if (c < N) return {31'b0, m_pend[c]};
        if (c == 100) return pend_vec();
        if (c == 101) return en_vec();
        return pend_vec() & en_vec();
    endfunction

    assign wc = classify(s_axil_awaddr_i);
    assign rc = classify(s_axil_araddr_i);

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] <= 1'b0;
                m_en[i] <= 1'b0;
            end
            m_irq <= 1'b0;
            m_out <= 0;
            m_resp <= 2'b00;
            m_rdata <= '0;
        end else begin
            m_irq <= |(pend_vec() & en_vec());
            if (m_out == 0 && s_axil_awvalid_i && s_axil_wvalid_i) begin
                m_out <= 1;
                m_resp <= wc < 0 ? 2'b10 : 2'b00;
                if (wc >= 0 && wc < N) m_pend[wc] <= 1'b1;
                else if (wc == 100) begin
                    for (int i = 0; i < N; i++) if (s_axil_wdata_i[i]) m_pend[i] <= 1'b0;
                end else if (wc == 101) begin
                    for (int i = 0; i < N; i++) m_en[i] <= s_axil_wdata_i[i];
                end
            end else if (m_out == 0 && s_axil_arvalid_i) begin
                m_out <= 2;
                m_resp <= rc < 0 ? 2'b10 : 2'b00;
                m_rdata <= read_val(rc);
            end else if ((m_out == 1 && s_axil_bready_i) || (m_out == 2 && s_axil_rready_i)) begin
                m_out <= 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if ($time > 2) begin
            chk("m_pending_o", 32'(pending_o), pend_vec());
            chk("m_irq_o", 32'(irq_o), 32'(m_irq));
            chk("m_bvalid_o", 32'(s_axil_bvalid_o), 32'(m_out == 1));
            chk("m_rvalid_o", 32'(s_axil_rvalid_o), 32'(m_out == 2));
            chk("m_awready_o", 32'(s_axil_awready_o),
                32'(!reset_i && m_out == 0 && s_axil_awvalid_i && s_axil_wvalid_i));
            chk("m_wready_o", 32'(s_axil_wready_o),
                32'(!reset_i && m_out == 0 && s_axil_awvalid_i && s_axil_wvalid_i));
            chk("m_arready_o", 32'(s_axil_arready_o),
                32'(!reset_i && m_out == 0 && s_axil_arvalid_i && !(s_axil_awvalid_i && s_axil_wvalid_i)));
            if (m_out == 1) chk("m_bresp_o", 32'(s_axil_bresp_o), 32'(m_resp));
            if (m_out == 2) begin
                chk("m_rresp_o", 32'(s_axil_rresp_o), 32'(m_resp));
                chk("m_rdata_o", s_axil_rdata_o, m_rdata);
            end
        end
    end

    // Entered and left at posedge+1 when bready is high; left at the response negedge otherwise.
    task automatic do_write(input logic [31:0] off, input logic [31:0] data,
                            output logic [1:0] resp, output logic [31:0] pend, output logic irq);
        bit ok = 0;
        s_axil_awaddr_i = BASE + off;
        s_axil_wdata_i = data;
        s_axil_awvalid_i = 1'b1;
        s_axil_wvalid_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (s_axil_awready_o) begin ok = 1; break; end
        end
        chk("aw_accept_timeout", 32'(ok), 32'd1);
        @(posedge clk_i); #1;
        s_axil_awvalid_i = 1'b0;
        s_axil_wvalid_i = 1'b0;
        @(negedge clk_i);
        chk("bvalid_after_accept", 32'(s_axil_bvalid_o), 32'd1);
        resp = s_axil_bresp_o;
        pend = 32'(pending_o);
        irq = irq_o;
        if (s_axil_bready_i) begin @(posedge clk_i); #1; end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ok = 0;
        s_axil_araddr_i = addr;
        s_axil_arvalid_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (s_axil_arready_o) begin ok = 1; break; end
        end
        chk("ar_accept_timeout", 32'(ok), 32'd1);
        @(posedge clk_i); #1;
        s_axil_arvalid_i = 1'b0;
        @(negedge clk_i);
        chk("rvalid_after_accept", 32'(s_axil_rvalid_o), 32'd1);
        data = s_axil_rdata_o;
        resp = s_axil_rresp_o;
        @(posedge clk_i); #1;
    endtask

    logic [1:0]  r;
    logic [31:0] p, d;
    logic        q;

    initial begin
        s_axil_awaddr_i = '0; s_axil_wdata_i = '0; s_axil_araddr_i = '0;
        s_axil_awprot_i = '0; s_axil_arprot_i = '0; s_axil_wstrb_i = 4'hf;
        s_axil_bready_i = 1'b1; s_axil_rready_i = 1'b1;
        s_axil_awvalid_i = 1'b1; s_axil_wvalid_i = 1'b1; s_axil_arvalid_i = 1'b1;
        #1 reset_i = 1'b1;
        @(negedge clk_i);
        chk("rst_pending", 32'(pending_o), 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_bvalid", 32'(s_axil_bvalid_o), 32'h0);
        chk("rst_rvalid", 32'(s_axil_rvalid_o), 32'h0);
        chk("rst_awready", 32'(s_axil_awready_o), 32'h0);
        chk("rst_arready", 32'(s_axil_arready_o), 32'h0);
        chk("rst_resp_data", {s_axil_bresp_o, s_axil_rresp_o, s_axil_rdata_o[27:0]}, 32'h0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        s_axil_awvalid_i = 1'b0; s_axil_wvalid_i = 1'b0; s_axil_arvalid_i = 1'b0;

        // Enable both sources, ring doorbell 1; irq lags pending by one cycle.
        do_write(32'h44, 32'h3, r, p, q);
        chk("en_resp", 32'(r), 32'h0);
        do_write(32'h04, 32'h0, r, p, q);
        chk("db1_resp", 32'(r), 32'h0);
        chk("db1_pending", p, 32'h2);
        chk("db1_irq_lag", 32'(q), 32'h0);
        chk("db1_irq", 32'(irq_o), 32'h1);

        do_write(32'h00, 32'h0, r, p, q);
        chk("db0_pending", p, 32'h3);
        do_read(BASE + 32'h40, d, r);
        chk("rd_pending", d, 32'h3);
        chk("rd_pending_resp", 32'(r), 32'h0);
        do_write(32'h40, 32'h1, r, p, q);
        chk("w1c_bit0", p, 32'h2);
        chk("w1c_bit0_irq", 32'(irq_o), 32'h1);
        do_write(32'h40, 32'h2, r, p, q);
        chk("w1c_bit1", p, 32'h0);
        chk("w1c_bit1_irq_lag", 32'(q), 32'h1);
        chk("w1c_bit1_irq", 32'(irq_o), 32'h0);

        do_read(BASE + 32'h44, d, r);
        chk("rd_enable", d, 32'h3);
        do_read(BASE + 32'h48, d, r);
        chk("rd_status_0", d, 32'h0);
        do_write(32'h00, 32'hdead_beef, r, p, q);
        do_write(32'h00, 32'h0, r, p, q);
        chk("db_repeat_resp", 32'(r), 32'h0);
        chk("db_repeat_pending", p, 32'h1);
        do_read(BASE + 32'h48, d, r);
        chk("rd_status_1", d, 32'h1);
        do_read(BASE + 32'h00, d, r);
        chk("rd_db0", d, 32'h1);
        do_read(BASE + 32'h04, d, r);
        chk("rd_db1", d, 32'h0);
        do_write(32'h44, 32'hffff_fffe, r, p, q);
        do_read(BASE + 32'h44, d, r);
        chk("rd_enable_trunc", d, 32'h2);
        chk("irq_masked", 32'(irq_o), 32'h0);
        do_write(32'h40, 32'hffff_fffc, r, p, q);
        chk("w1c_upper_ignored", p, 32'h1);

        // Unmapped accesses.
        do_write(32'h10, 32'h0, r, p, q);
        chk("unmap_w10_resp", 32'(r), 32'h2);
        chk("unmap_w10_pending", p, 32'h1);
        do_write(32'h42, 32'h1, r, p, q);
        chk("unmap_misalign_resp", 32'(r), 32'h2);
        do_read(BASE + 32'h60, d, r);
        chk("unmap_r60_resp", 32'(r), 32'h2);
        chk("unmap_r60_data", d, 32'h0);
        do_read(BASE + 32'h4c, d, r);
        chk("unmap_r4c", {30'(d), r}, 32'h2);
        do_read(BASE - 32'h4, d, r);
        chk("unmap_below_base", {30'(d), r}, 32'h2);
        do_read(BASE + 32'h08, d, r);
        chk("unmap_db2", {30'(d), r}, 32'h2);

        // Simultaneous write and read: write wins, read sees its effect.
        do_write(32'h44, 32'h3, r, p, q);
        s_axil_awaddr_i = BASE + 32'h04; s_axil_awvalid_i = 1'b1; s_axil_wvalid_i = 1'b1;
        s_axil_araddr_i = BASE + 32'h40; s_axil_arvalid_i = 1'b1;
        @(negedge clk_i);
        chk("sim_awready", 32'(s_axil_awready_o), 32'h1);
        chk("sim_arready", 32'(s_axil_arready_o), 32'h0);
        @(posedge clk_i); #1;
        s_axil_awvalid_i = 1'b0; s_axil_wvalid_i = 1'b0;
        @(negedge clk_i);
        chk("sim_bvalid", 32'(s_axil_bvalid_o), 32'h1);
        chk("sim_arready_busy", 32'(s_axil_arready_o), 32'h0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("sim_arready_after_b", 32'(s_axil_arready_o), 32'h1);
        @(posedge clk_i); #1;
        s_axil_arvalid_i = 1'b0;
        @(negedge clk_i);
        chk("sim_rvalid", 32'(s_axil_rvalid_o), 32'h1);
        chk("sim_rdata", s_axil_rdata_o, 32'h3);
        @(posedge clk_i); #1;

        // Back-pressure on B: response held, nothing new accepted.
        s_axil_bready_i = 1'b0;
        do_write(32'h40, 32'h1, r, p, q);
        @(posedge clk_i); #1;
        s_axil_awaddr_i = BASE; s_axil_awvalid_i = 1'b1; s_axil_wvalid_i = 1'b1;
        s_axil_arvalid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            chk("hold_bvalid", 32'(s_axil_bvalid_o), 32'h1);
            chk("hold_bresp", 32'(s_axil_bresp_o), 32'h0);
            chk("hold_readies", {s_axil_awready_o, s_axil_wready_o, s_axil_arready_o}, 32'h0);
        end
        @(posedge clk_i); #1;
        s_axil_awvalid_i = 1'b0; s_axil_wvalid_i = 1'b0; s_axil_arvalid_i = 1'b0;
        s_axil_bready_i = 1'b1;
        @(negedge clk_i);
        chk("hold_release_bvalid", 32'(s_axil_bvalid_o), 32'h1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("hold_done_bvalid", 32'(s_axil_bvalid_o), 32'h0);
        chk("hold_pending", 32'(pending_o), 32'h2);
        @(posedge clk_i); #1;

        // Reset while a write response is pending.
        s_axil_bready_i = 1'b0;
        do_write(32'h00, 32'h0, r, p, q);
        chk("pre_reset_pending", p, 32'h3);
        #1 reset_i = 1'b1;
        #1;
        chk("arst_bvalid", 32'(s_axil_bvalid_o), 32'h0);
        chk("arst_pending", 32'(pending_o), 32'h0);
        chk("arst_irq", 32'(irq_o), 32'h0);
        @(posedge clk_i); @(posedge clk_i); #1;
        reset_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("post_reset_no_resp", {s_axil_bvalid_o, s_axil_rvalid_o}, 32'h0);
        end
        @(posedge clk_i); #1;
        s_axil_bready_i = 1'b1;
        do_write(32'h44, 32'h1, r, p, q);
        do_write(32'h00, 32'h0, r, p, q);
        do_read(BASE + 32'h48, d, r);
        chk("post_reset_status", d, 32'h1);
        @(negedge clk_i);
        chk("post_reset_irq", 32'(irq_o), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
